alu_cmd_sequencer: RTL

//  Sits between the host command queue and the 64-bit ALU engine's vld/rdy/done command interface.

---
 rtl/alu_cmd_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command sequencer between the host queue and the 64-bit ALU engine: enforces the
// INIT/HLT/RST protocol, tags arithmetic commands for out-of-order completion, flags errors.
module alu_cmd_sequencer #(
    parameter  int NTAG    = 8,
    parameter  int LATENCY = 7,
    parameter  int DW      = 64,
    localparam int TW      = $clog2(NTAG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_vld,
    output logic          req_rdy,
    input  logic [2:0]    req_cmd,
    input  logic [DW-1:0] req_opd1,
    input  logic [DW-1:0] req_opd2,
    output logic          eng_vld,
    input  logic          eng_rdy,
    output logic [2:0]    eng_cmd,
    output logic [DW-1:0] eng_opd1,
    output logic [DW-1:0] eng_opd2,
    output logic [TW-1:0] eng_tag,
    input  logic          done_i,
    input  logic [TW-1:0] done_tag,
    input  logic [2:0]    done_cmd,
    output logic [4:0]    outstanding,
    output logic [2:0]    state_o,
    output logic          err_timeout,
    output logic          err_bad_done,
    output logic          err_illegal
);

    localparam int CW = $clog2(LATENCY + 1);

    localparam logic [2:0] CMD_RST  = 3'd0;
    localparam logic [2:0] CMD_INIT = 3'd1;
    localparam logic [2:0] CMD_ADD  = 3'd2;
    localparam logic [2:0] CMD_REM  = 3'd6;
    localparam logic [2:0] CMD_HLT  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_HLT   = 3'd4,
        S_RST   = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic            r_eng_vld;
    logic [2:0]      r_eng_cmd;
    logic [DW-1:0]   r_eng_opd1, r_eng_opd2;
    logic [TW-1:0]   r_eng_tag;
    logic [NTAG-1:0] r_bitmap;
    logic [2:0]      r_optab [NTAG];
    logic [4:0]      r_outstanding;
    logic [CW-1:0]   r_tocnt;
    logic            r_err_timeout, r_err_bad_done, r_err_illegal;

    logic            w_hs, w_req_rdy, w_acc, w_arith, w_issue;
    logic            w_done_ok, w_done_bad;
    logic [TW-1:0]   w_free_tag;
    logic [NTAG-1:0] w_set, w_clr;
    logic            w_ld;
    logic [2:0]      w_ld_cmd;
    logic [DW-1:0]   w_ld_opd1, w_ld_opd2;
    logic [TW-1:0]   w_ld_tag;

    assign w_hs      = r_eng_vld & eng_rdy;
    assign w_req_rdy = (r_state == S_RUN) & (~r_eng_vld | eng_rdy) &
                       ((req_cmd == CMD_HLT) | (r_outstanding < 5'(NTAG)));
    assign w_acc     = req_vld & w_req_rdy;
    assign w_arith   = (req_cmd >= CMD_ADD) & (req_cmd <= CMD_REM);
    assign w_issue   = w_acc & w_arith;
    assign w_done_ok  = done_i & r_bitmap[done_tag] & (r_optab[done_tag] == done_cmd);
    assign w_done_bad = done_i & ~w_done_ok;

    // Allocation sees the bitmap before this cycle's release, so a freed tag is never reused same cycle.
    always_comb begin
        w_free_tag = '0;
        for (int i = NTAG - 1; i >= 0; i--)
            if (!r_bitmap[i]) w_free_tag = TW'(i);
    end

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_issue)   w_set[w_free_tag] = 1'b1;
        if (w_done_ok) w_clr[done_tag]   = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_ld_cmd    = CMD_RST;
        w_ld_opd1   = '0;
        w_ld_opd2   = '0;
        w_ld_tag    = '0;
        case (r_state)
            S_IDLE: begin
                w_state_nxt = S_INIT;
                w_ld        = 1'b1;
                w_ld_cmd    = CMD_INIT;
            end
            S_INIT: if (w_hs) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_acc && req_cmd == CMD_HLT) begin
                    w_state_nxt = S_DRAIN;
                end else if (w_issue) begin
                    w_ld      = 1'b1;
                    w_ld_cmd  = req_cmd;
                    w_ld_opd1 = req_opd1;
                    w_ld_opd2 = req_opd2;
                    w_ld_tag  = w_free_tag;
                end
            end
            S_DRAIN: begin
                if (r_outstanding == 5'd0 && !r_eng_vld) begin
                    w_state_nxt = S_HLT;
                    w_ld        = 1'b1;
                    w_ld_cmd    = CMD_HLT;
                end
            end
            S_HLT: begin
                if (w_hs) begin
                    w_state_nxt = S_RST;
                    w_ld        = 1'b1;
                    w_ld_cmd    = CMD_RST;
                end
            end
            S_RST: begin
                if (w_hs) begin
                    w_state_nxt = S_INIT;
                    w_ld        = 1'b1;
                    w_ld_cmd    = CMD_INIT;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One-entry output register; only reloaded when empty or draining this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_eng_vld  <= 1'b0;
            r_eng_cmd  <= '0;
            r_eng_opd1 <= '0;
            r_eng_opd2 <= '0;
            r_eng_tag  <= '0;
        end else if (w_ld) begin
            r_eng_vld  <= 1'b1;
            r_eng_cmd  <= w_ld_cmd;
            r_eng_opd1 <= w_ld_opd1;
            r_eng_opd2 <= w_ld_opd2;
            r_eng_tag  <= w_ld_tag;
        end else if (w_hs) begin
            r_eng_vld  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bitmap      <= '0;
            r_outstanding <= '0;
            for (int i = 0; i < NTAG; i++) r_optab[i] <= '0;
        end else begin
            r_bitmap      <= (r_bitmap | w_set) & ~w_clr;
            r_outstanding <= r_outstanding + 5'(w_issue) - 5'(w_done_ok);
            if (w_issue) r_optab[w_free_tag] <= req_cmd;
        end
    end

    // Stall counter saturates at LATENCY; the engine command is held, never aborted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tocnt       <= '0;
            r_err_timeout <= 1'b0;
        end else if (w_hs) begin
            r_tocnt <= '0;
        end else if (r_eng_vld) begin
            if (r_tocnt != CW'(LATENCY))     r_tocnt       <= r_tocnt + 1'b1;
            if (r_tocnt == CW'(LATENCY - 1)) r_err_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_bad_done <= 1'b0;
            r_err_illegal  <= 1'b0;
        end else begin
            r_err_bad_done <= w_done_bad;
            r_err_illegal  <= w_acc & ((req_cmd == CMD_RST) | (req_cmd == CMD_INIT));
        end
    end

    assign req_rdy      = w_req_rdy;
    assign eng_vld      = r_eng_vld;
    assign eng_cmd      = r_eng_cmd;
    assign eng_opd1     = r_eng_opd1;
    assign eng_opd2     = r_eng_opd2;
    assign eng_tag      = r_eng_tag;
    assign outstanding  = r_outstanding;
    assign state_o      = r_state;
    assign err_timeout  = r_err_timeout;
    assign err_bad_done = r_err_bad_done;
    assign err_illegal  = r_err_illegal;

endmodule
